// File: rtl/debounce_bank_if.sv
// Signal bundle for debounce_bank: raw inputs and mode select in, debounced
// levels, event pulses and mode-selected outputs back.
// long_press exists only when DEBOUNCE_BANK_LONGPRESS_EN is defined.
interface debounce_bank_if #(
  parameter int N_CH = 6
);
  logic [N_CH-1:0]   raw_in;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   db_level;
  logic [N_CH-1:0]   sig_out;
  logic [N_CH-1:0]   press_pulse;
  logic [N_CH-1:0]   release_pulse;
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
  logic [N_CH-1:0]   long_press;
`endif

  // Drives the inputs and observes the outputs (stimulus side).
  modport master (
    output raw_in, mode,
    input  db_level, sig_out, press_pulse, release_pulse
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    , input long_press
`endif
  );

  // The debouncer itself.
  modport slave (
    input  raw_in, mode,
    output db_level, sig_out, press_pulse, release_pulse
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    , output long_press
`endif
  );
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debouncers. Each raw input is brought into
// the clk domain by a 2-flop synchronizer, then accepted only after DB_CYCLES
// consecutive clocks of disagreement with the current debounced level.
// Produces press/release pulses, a press-toggled register and a per-channel
// mode-selected output.
// Optional long-press detection: define DEBOUNCE_BANK_LONGPRESS_EN.
module debounce_bank #(
  parameter int N_CH        = 6,
  parameter int DB_CYCLES   = 5,
  parameter int CNT_W       = 28,
  parameter int LONG_CYCLES = 50
) (
  input logic            clk,
  input logic            reset_tmp,
  debounce_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_LEVEL   = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_PRESS   = 2'b10,
    MODE_RELEASE = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_CH-1:0]  r_sync1;
  logic [N_CH-1:0]  r_sync2;
  logic [N_CH-1:0]  r_db;
  logic [N_CH-1:0]  r_press;
  logic [N_CH-1:0]  r_rel;
  logic [N_CH-1:0]  r_tog;
  logic [CNT_W-1:0] r_cnt [N_CH];
  logic [N_CH-1:0]  w_accept;
  logic [N_CH-1:0]  w_sig;

  // Two-stage synchronizer for the asynchronous raw inputs.
  always_ff @(posedge clk or posedge reset_tmp) begin
    if (reset_tmp) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // giving two real flop stages; blocking would collapse them into one.
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    // The new level is accepted on the DB_CYCLES-th consecutive differing clock.
    assign w_accept[ch] = (r_sync2[ch] != r_db[ch]) && (r_cnt[ch] == CNT_LAST);

    // Stability counter: clears on agreement or acceptance, saturates otherwise.
    always_ff @(posedge clk or posedge reset_tmp) begin
      if (reset_tmp) begin
        // NOTE: this counter array is plain flops, so it is cleared by reset
        // like any register; only true RAM macros are left unreset.
        r_cnt[ch] <= '0;
      end else if ((r_sync2[ch] == r_db[ch]) || w_accept[ch]) begin
        r_cnt[ch] <= '0;
      end else if (r_cnt[ch] != '1) begin
        r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
      end
    end
  end

  // Debounced level, registered edge pulses and the press-toggled register.
  always_ff @(posedge clk or posedge reset_tmp) begin
    if (reset_tmp) begin
      r_db    <= '0;
      r_press <= '0;
      r_rel   <= '0;
      r_tog   <= '0;
    end else begin
      r_db    <= r_db ^ w_accept;
      r_press <= w_accept & r_sync2;
      r_rel   <= w_accept & ~r_sync2;
      r_tog   <= r_tog ^ (w_accept & r_sync2);
    end
  end

  // Per-channel output mux; the toggle register runs in every mode.
  always_comb begin
    // NOTE: default first so every path assigns w_sig and no latch is inferred.
    w_sig = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      case (mode_e'(bus.mode[2*ch +: 2]))
        MODE_LEVEL:   w_sig[ch] = r_db[ch];
        MODE_TOGGLE:  w_sig[ch] = r_tog[ch];
        MODE_PRESS:   w_sig[ch] = r_press[ch];
        MODE_RELEASE: w_sig[ch] = r_rel[ch];
        default:      w_sig[ch] = 1'b0;
      endcase
    end
  end

  assign bus.db_level      = r_db;
  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_rel;
  assign bus.sig_out       = w_sig;

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  logic [HOLD_W-1:0] r_hold [N_CH];
  logic              r_long [N_CH];

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_long
    // Hold counter and flag: flag rises LONG_CYCLES clocks after the level
    // rose and drops the clock after the level falls.
    always_ff @(posedge clk or posedge reset_tmp) begin
      if (reset_tmp) begin
        r_hold[ch] <= '0;
        r_long[ch] <= 1'b0;
      end else if (!r_db[ch]) begin
        r_hold[ch] <= '0;
        r_long[ch] <= 1'b0;
      end else begin
        if (r_hold[ch] != HOLD_W'(LONG_CYCLES)) begin
          r_hold[ch] <= r_hold[ch] + HOLD_W'(1);
        end
        if (r_hold[ch] >= HOLD_W'(LONG_CYCLES - 1)) begin
          r_long[ch] <= 1'b1;
        end
      end
    end

    assign bus.long_press[ch] = r_long[ch];
  end
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank. A behavioural model keeps a window of
// raw samples per channel and accepts a new level once DB_CYCLES synchronized
// samples in a row disagree with the current level.
module tb_debounce_bank;
  localparam int N  = 6;
  localparam int DB = 5;
  localparam int CW = 28;
  localparam int LC = 50;
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
  localparam int VW = 5 * N;
`else
  localparam int VW = 4 * N;
`endif

  logic clk = 1'b0;
  logic reset_tmp = 1'b1;

  debounce_bank_if #(.N_CH(N)) bus ();

  debounce_bank #(
    .N_CH(N), .DB_CYCLES(DB), .CNT_W(CW), .LONG_CYCLES(LC)
  ) dut (
    .clk(clk),
    .reset_tmp(reset_tmp),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state. hist[ch][j] = raw value sampled j edges ago (0 = this edge).
  bit           hist [N][DB+2];
  logic [N-1:0] m_db, m_press, m_rel, m_tog, m_long;
  int           rise_edge [N];
  int           cyc;

  function automatic logic [N-1:0] exp_sig();
    logic [N-1:0] s;
    s = '0;
    for (int ch = 0; ch < N; ch++) begin
      case (bus.mode[2*ch +: 2])
        2'b00: s[ch] = m_db[ch];
        2'b01: s[ch] = m_tog[ch];
        2'b10: s[ch] = m_press[ch];
        default: s[ch] = m_rel[ch];
      endcase
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] model_vec();
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    return {m_long, m_db, m_press, m_rel, exp_sig()};
`else
    return {m_db, m_press, m_rel, exp_sig()};
`endif
  endfunction

  function automatic logic [VW-1:0] dut_vec();
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    return {bus.long_press, bus.db_level, bus.press_pulse, bus.release_pulse, bus.sig_out};
`else
    return {bus.db_level, bus.press_pulse, bus.release_pulse, bus.sig_out};
`endif
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) begin
      for (int j = 0; j < DB + 2; j++) hist[ch][j] = 1'b0;
      rise_edge[ch] = 0;
    end
    m_db = '0; m_press = '0; m_rel = '0; m_tog = '0; m_long = '0;
    cyc = 0;
  endtask

  // One rising edge: advance the model with the inputs the DUT sampled, then
  // settle 1 time unit so outputs can be compared away from the edge.
  task automatic tick();
    bit acc;
    bit old;
    @(posedge clk);
    cyc++;
    for (int ch = 0; ch < N; ch++) begin
      for (int j = DB + 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
      hist[ch][0] = bus.raw_in[ch];
      // Synchronized samples are the raw ones two edges old.
      acc = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (hist[ch][j] == m_db[ch]) acc = 1'b0;
      old = m_db[ch];
      m_long[ch]  = old && ((cyc - rise_edge[ch]) >= LC);
      m_press[ch] = acc && !old;
      m_rel[ch]   = acc && old;
      if (acc) m_db[ch] = ~old;
      if (acc && !old) begin
        m_tog[ch] = ~m_tog[ch];
        rise_edge[ch] = cyc;
      end
    end
    #1;
  endtask

  // Reset asserted just after an edge, held across two edges, then released.
  task automatic do_reset();
    reset_tmp = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_tmp = 1'b0;
  endtask

  task automatic test_reset();
    bus.raw_in = '1;
    bus.mode   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.db_level !== '0) begin failures++; $display("FAIL reset_db got=%h exp=%h", bus.db_level, 6'h0); end
    checks++; if (bus.sig_out !== '0) begin failures++; $display("FAIL reset_sig got=%h exp=%h", bus.sig_out, 6'h0); end
    checks++; if (bus.press_pulse !== '0) begin failures++; $display("FAIL reset_press got=%h exp=%h", bus.press_pulse, 6'h0); end
    checks++; if (bus.release_pulse !== '0) begin failures++; $display("FAIL reset_release got=%h exp=%h", bus.release_pulse, 6'h0); end
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    checks++; if (bus.long_press !== '0) begin failures++; $display("FAIL reset_long got=%h exp=%h", bus.long_press, 6'h0); end
`endif
    bus.raw_in = '0;
    do_reset();
  endtask

  task automatic test_clean_step();
    int lat;
    int npress;
    do_reset();
    bus.raw_in = '0;
    bus.mode   = '0;
    repeat (3) begin
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL step_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
    end
    bus.raw_in[0] = 1'b1;
    lat = -1;
    npress = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL step_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
      if (lat < 0 && bus.db_level[0]) lat = n;
      if (bus.press_pulse[0]) npress++;
    end
    checks++; if (lat !== 7) begin failures++; $display("FAIL step_latency got=%0d exp=%0d", lat, 7); end
    checks++; if (npress !== 1) begin failures++; $display("FAIL step_press_count got=%0d exp=%0d", npress, 1); end
  endtask

  task automatic test_glitch();
    int bad;
    bus.mode[3:2] = 2'b10;
    bad = 0;
    bus.raw_in[1] = 1'b1;
    for (int n = 0; n < 15; n++) begin
      if (n == 3) bus.raw_in[1] = 1'b0;
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
      if (bus.db_level[1] || bus.press_pulse[1] || bus.sig_out[1]) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL glitch_quiet got=%0d exp=%0d", bad, 0); end
  endtask

  task automatic test_toggle();
    int npress;
    int nrel;
    logic exp_t;
    do_reset();
    bus.raw_in = '0;
    bus.mode = '0;
    bus.mode[5:4] = 2'b01;
    npress = 0;
    nrel = 0;
    for (int p = 0; p < 3; p++) begin
      exp_t = (p % 2 == 0) ? 1'b1 : 1'b0;
      bus.raw_in[2] = 1'b1;
      repeat (9) begin
        tick();
        checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL toggle_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
        if (bus.press_pulse[2]) npress++;
      end
      checks++; if (bus.sig_out[2] !== exp_t) begin failures++; $display("FAIL toggle_after_press%0d got=%b exp=%b", p, bus.sig_out[2], exp_t); end
      bus.raw_in[2] = 1'b0;
      repeat (9) begin
        tick();
        checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL toggle_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
        if (bus.release_pulse[2]) nrel++;
      end
      checks++; if (bus.sig_out[2] !== exp_t) begin failures++; $display("FAIL toggle_after_release%0d got=%b exp=%b", p, bus.sig_out[2], exp_t); end
    end
    checks++; if (npress !== 3) begin failures++; $display("FAIL toggle_press_count got=%0d exp=%0d", npress, 3); end
    checks++; if (nrel !== 3) begin failures++; $display("FAIL toggle_release_count got=%0d exp=%0d", nrel, 3); end
  endtask

  task automatic test_simultaneous();
    int hits;
    int hit_at;
    do_reset();
    bus.mode = '0;
    bus.raw_in = '1;
    hits = 0;
    hit_at = -1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL simul_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
      if (bus.db_level == 6'h3F && bus.press_pulse == 6'h3F) begin
        hits++;
        hit_at = n;
      end
    end
    checks++; if (hits !== 1) begin failures++; $display("FAIL simul_hits got=%0d exp=%0d", hits, 1); end
    checks++; if (hit_at !== 7) begin failures++; $display("FAIL simul_cycle got=%0d exp=%0d", hit_at, 7); end
  endtask

  task automatic test_reset_midcount();
    int lat;
    do_reset();
    bus.mode = '0;
    bus.mode[7:6] = 2'b01;
    bus.raw_in = 6'h3E;
    repeat (10) begin
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL midrst_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
    end
    bus.raw_in[0] = 1'b1;
    repeat (5) begin
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL midrst_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
    end
    // Asynchronous: outputs must clear before any further clock edge.
    reset_tmp = 1'b1;
    #1;
    checks++; if (bus.db_level !== '0) begin failures++; $display("FAIL midrst_db got=%h exp=%h", bus.db_level, 6'h0); end
    checks++; if (bus.sig_out !== '0) begin failures++; $display("FAIL midrst_sig got=%h exp=%h", bus.sig_out, 6'h0); end
    checks++; if (bus.press_pulse !== '0 || bus.release_pulse !== '0) begin failures++; $display("FAIL midrst_pulses got=%h exp=%h", {bus.press_pulse, bus.release_pulse}, 12'h0); end
    do_reset();
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL midrst_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
      if (lat < 0 && bus.db_level[0]) lat = n;
    end
    checks++; if (lat !== 7) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, 7); end
  endtask

  task automatic test_random();
    int run_left [N];
    do_reset();
    bus.raw_in = '0;
    bus.mode = 12'($urandom());
    for (int ch = 0; ch < N; ch++) run_left[ch] = $urandom_range(1, 2 * DB + 2);
    for (int n = 0; n < 3000; n++) begin
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
      for (int ch = 0; ch < N; ch++) begin
        run_left[ch]--;
        if (run_left[ch] <= 0) begin
          bus.raw_in[ch] = ~bus.raw_in[ch];
          run_left[ch] = $urandom_range(1, 2 * DB + 2);
        end
      end
      if (n % 64 == 63) bus.mode = 12'($urandom());
    end
  endtask

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
  task automatic test_long_press();
    int db_rise, db_fall, lp_rise, lp_fall;
    logic prev_db, prev_lp;
    do_reset();
    bus.mode = '0;
    bus.raw_in = '0;
    bus.raw_in[0] = 1'b1;
    db_rise = -1; db_fall = -1; lp_rise = -1; lp_fall = -1;
    prev_db = 1'b0; prev_lp = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL long_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec()); end
      if (bus.db_level[0] && !prev_db) db_rise = n;
      if (!bus.db_level[0] && prev_db) db_fall = n;
      if (bus.long_press[0] && !prev_lp) lp_rise = n;
      if (!bus.long_press[0] && prev_lp) lp_fall = n;
      prev_db = bus.db_level[0];
      prev_lp = bus.long_press[0];
      if (db_rise > 0 && n == db_rise + 60) bus.raw_in[0] = 1'b0;
    end
    checks++; if (lp_rise - db_rise !== LC || db_rise < 0) begin failures++; $display("FAIL long_rise_delay got=%0d exp=%0d", lp_rise - db_rise, LC); end
    checks++; if (lp_fall - db_fall !== 1 || db_fall < 0) begin failures++; $display("FAIL long_fall_delay got=%0d exp=%0d", lp_fall - db_fall, 1); end
  endtask
`endif

  initial begin
    bus.raw_in = '0;
    bus.mode   = '0;
    model_reset();
    test_reset();
    test_clean_step();
    test_glitch();
    test_toggle();
    test_simultaneous();
    test_reset_midcount();
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    test_long_press();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
